apb_timer_seq: RTL

APB master that sequences the system timer peripheral on behalf of firmware-free hardware clients. It accepts a single timer command, then programs the timer over APB: stop, prescaler, auto-reload, and control with start. It can optionally poll the timer status register until the update event fires, a poll limit expires, or the command is aborted. The block sits between a hardware requester and the timer's APB slave port, and is the only APB master on that segment.

---
 rtl/apb_timer_seq.sv | 280 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/apb_timer_seq.sv
// ---------------------------------------------------------------------------
// apb_timer_seq
//
// APB master that programs the system timer for a hardware requester. One
// command is accepted at a time. The block writes CR=0, PSC, ARR and CR (with
// the start bit set), then optionally polls SR until the update event is seen,
// the poll limit is reached, or the requester aborts. An abort stops the timer
// with a final CR=0 write.
//
// Ports
//   PCLK, PRESETn          clock, asynchronous active-low reset
//   cmd_valid / cmd_ready  command handshake (ready only while idle)
//   cmd_psc, cmd_arr       prescaler and auto-reload values
//   cmd_mode, cmd_irq_en   CR[3:2] and CR[1]
//   cmd_wait               poll SR after start
//   abort                  level; only acted on during the poll phase
//   PSEL..PRDATA           APB master port (no PREADY: every transfer is 2 cycles)
//   done                   one-cycle completion pulse
//   done_status            00 started, 01 event, 10 timeout, 11 aborted
//   done_cnt               SR[31:16] from the most recent SR read
//   busy                   high from the cycle after accept through done
// ---------------------------------------------------------------------------
module apb_timer_seq #(
  parameter logic [31:0] BASE_ADDR = 32'h4010_0000,
  parameter int unsigned POLL_GAP  = 4,
  parameter logic [15:0] MAX_POLLS = 16'd1000
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_psc,
  input  logic [15:0] cmd_arr,
  input  logic [1:0]  cmd_mode,
  input  logic        cmd_irq_en,
  input  logic        cmd_wait,
  input  logic        abort,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  output logic        done,
  output logic [1:0]  done_status,
  output logic [15:0] done_cnt,
  output logic        busy
);

  localparam logic [31:0] ADDR_SR  = BASE_ADDR + 32'h0;
  localparam logic [31:0] ADDR_PSC = BASE_ADDR + 32'h4;
  localparam logic [31:0] ADDR_ARR = BASE_ADDR + 32'h8;
  localparam logic [31:0] ADDR_CR  = BASE_ADDR + 32'hC;

  // Transfer index within a command; STEP_SR is repeated for every poll.
  localparam logic [2:0] STEP_CR_CLR = 3'd0;
  localparam logic [2:0] STEP_PSC    = 3'd1;
  localparam logic [2:0] STEP_ARR    = 3'd2;
  localparam logic [2:0] STEP_CR_GO  = 3'd3;
  localparam logic [2:0] STEP_SR     = 3'd4;

  localparam logic [1:0] ST_STARTED = 2'b00;
  localparam logic [1:0] ST_EVENT   = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_ABORTED = 2'b11;

  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = (POLL_GAP == 0) ? '0 : GAP_W'(POLL_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_GAP,
    S_STOP_SETUP,
    S_STOP_ACCESS,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         step_q, step_d;
  logic [3:0]         psc_q, psc_d;
  logic [15:0]        arr_q, arr_d;
  logic [1:0]         mode_q, mode_d;
  logic               irq_en_q, irq_en_d;
  logic               wait_q, wait_d;
  logic [15:0]        poll_cnt_q, poll_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [31:0]        paddr_q, paddr_d;
  logic [31:0]        pwdata_q, pwdata_d;
  logic               pwrite_q, pwrite_d;
  logic [1:0]         status_q, status_d;
  logic [15:0]        cnt_q, cnt_d;

  logic               load_en;
  logic [2:0]         load_step;
  logic [15:0]        poll_inc;

  // Only the event flag and the count field of SR carry meaning here.
  logic               unused_prdata;
  assign unused_prdata = ^PRDATA[15:1];

  assign poll_inc = poll_cnt_q + 16'd1;

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    psc_d      = psc_q;
    arr_d      = arr_q;
    mode_d     = mode_q;
    irq_en_d   = irq_en_q;
    wait_d     = wait_q;
    poll_cnt_d = poll_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    pwrite_d   = pwrite_q;
    status_d   = status_q;
    cnt_d      = cnt_q;
    load_en    = 1'b0;
    load_step  = step_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          psc_d      = cmd_psc;
          arr_d      = cmd_arr;
          mode_d     = cmd_mode;
          irq_en_d   = cmd_irq_en;
          wait_d     = cmd_wait;
          poll_cnt_d = '0;
          step_d     = STEP_CR_CLR;
          load_en    = 1'b1;
          load_step  = STEP_CR_CLR;
          state_d    = S_SETUP;
        end
      end

      S_SETUP: state_d = S_ACCESS;

      S_ACCESS: begin
        if (step_q < STEP_CR_GO) begin
          step_d    = step_q + 3'd1;
          load_en   = 1'b1;
          load_step = step_q + 3'd1;
          state_d   = S_SETUP;
        end else if (step_q == STEP_CR_GO) begin
          if (wait_q) begin
            step_d    = STEP_SR;
            load_en   = 1'b1;
            load_step = STEP_SR;
            state_d   = S_SETUP;
          end else begin
            status_d = ST_STARTED;
            state_d  = S_DONE;
          end
        end else begin
          // SR read completes on this edge. Priority: event, then abort,
          // then timeout.
          cnt_d = PRDATA[31:16];
          if (PRDATA[0]) begin
            status_d = ST_EVENT;
            state_d  = S_DONE;
          end else begin
            poll_cnt_d = poll_inc;
            if (abort) begin
              load_en   = 1'b1;
              load_step = STEP_CR_CLR;
              state_d   = S_STOP_SETUP;
            end else if (poll_inc == MAX_POLLS) begin
              status_d = ST_TIMEOUT;
              state_d  = S_DONE;
            end else if (POLL_GAP == 0) begin
              state_d = S_SETUP;
            end else begin
              gap_cnt_d = GAP_LOAD;
              state_d   = S_GAP;
            end
          end
        end
      end

      S_GAP: begin
        if (abort) begin
          load_en   = 1'b1;
          load_step = STEP_CR_CLR;
          state_d   = S_STOP_SETUP;
        end else if (gap_cnt_q == '0) begin
          state_d = S_SETUP;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end

      S_STOP_SETUP: state_d = S_STOP_ACCESS;

      S_STOP_ACCESS: begin
        status_d = ST_ABORTED;
        state_d  = S_DONE;
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    // Address/data/direction are registered one cycle ahead of SETUP so they
    // are stable for both phases of the transfer.
    if (load_en) begin
      pwrite_d = 1'b1;
      pwdata_d = '0;
      case (load_step)
        STEP_CR_CLR: paddr_d = ADDR_CR;
        STEP_PSC: begin
          paddr_d  = ADDR_PSC;
          pwdata_d = {28'b0, psc_q};
        end
        STEP_ARR: begin
          paddr_d  = ADDR_ARR;
          pwdata_d = {16'b0, arr_q};
        end
        STEP_CR_GO: begin
          paddr_d  = ADDR_CR;
          pwdata_d = {28'b0, mode_q, irq_en_q, 1'b1};
        end
        default: begin
          paddr_d  = ADDR_SR;
          pwrite_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= S_IDLE;
      step_q     <= STEP_CR_CLR;
      psc_q      <= '0;
      arr_q      <= '0;
      mode_q     <= '0;
      irq_en_q   <= 1'b0;
      wait_q     <= 1'b0;
      poll_cnt_q <= '0;
      gap_cnt_q  <= '0;
      paddr_q    <= BASE_ADDR;
      pwdata_q   <= '0;
      pwrite_q   <= 1'b0;
      status_q   <= ST_STARTED;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      psc_q      <= psc_d;
      arr_q      <= arr_d;
      mode_q     <= mode_d;
      irq_en_q   <= irq_en_d;
      wait_q     <= wait_d;
      poll_cnt_q <= poll_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      pwrite_q   <= pwrite_d;
      status_q   <= status_d;
      cnt_q      <= cnt_d;
    end
  end

  assign PSEL        = (state_q == S_SETUP) || (state_q == S_ACCESS) ||
                       (state_q == S_STOP_SETUP) || (state_q == S_STOP_ACCESS);
  assign PENABLE     = (state_q == S_ACCESS) || (state_q == S_STOP_ACCESS);
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign cmd_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign done_status = status_q;
  assign done_cnt    = cnt_q;

endmodule
